// File: rtl/pixel_stream_writer.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_stream_writer
//  Purpose  : Parses framed panel/address/RGB packets into single-cycle pixel
//             writes on the shared panel control bus, with error accounting.
//  Revision : 1.0
// ============================================================================
module pixel_stream_writer #(
  parameter int NUM_PANELS       = 6,
  parameter int PIXELS_PER_PANEL = 4096
) (
  input  logic        ctrl_clock,
  input  logic        ctrl_reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic [7:0]  ctrl_en,
  output logic [15:0] ctrl_addr,
  output logic [23:0] ctrl_wdat,
  output logic [15:0] pkt_count,
  output logic [15:0] err_count
);

  localparam logic [7:0]  c_MAX_PANEL = 8'(NUM_PANELS);
  localparam logic [16:0] c_PIX_LIMIT = 17'(PIXELS_PER_PANEL);

  typedef enum logic [2:0] {
    HDR_PANEL   = 3'd0,
    HDR_ADDR_HI = 3'd1,
    HDR_ADDR_LO = 3'd2,
    PIX_R       = 3'd3,
    PIX_G       = 3'd4,
    PIX_B       = 3'd5,
    DROP        = 3'd6
  } state_t;

  state_t      state_q;
  logic [7:0]  panel_q;
  logic        bad_q;
  logic [7:0]  addr_hi_q;
  logic [15:0] ptr_q;
  logic [7:0]  r_q;
  logic [7:0]  g_q;
  logic [7:0]  en_q;
  logic [15:0] addr_q;
  logic [23:0] wdat_q;
  logic [15:0] pkt_q;
  logic [15:0] err_q;

  logic        w_accept;
  logic [15:0] w_addr;
  logic        w_addr_ok;
  logic        w_ptr_end;

  assign in_ready  = ~ctrl_reset;
  assign w_accept  = in_valid & ~ctrl_reset;
  assign w_addr    = {addr_hi_q, in_data};
  assign w_addr_ok = ({1'b0, w_addr} < c_PIX_LIMIT);
  // The write in PIX_B uses ptr_q; this flags it as the panel's final address.
  assign w_ptr_end = (({1'b0, ptr_q} + 17'd1) == c_PIX_LIMIT);

  always_ff @(posedge ctrl_clock) begin
    if (ctrl_reset) begin
      state_q   <= HDR_PANEL;
      panel_q   <= '0;
      bad_q     <= 1'b0;
      addr_hi_q <= '0;
      ptr_q     <= '0;
      r_q       <= '0;
      g_q       <= '0;
      en_q      <= '0;
      addr_q    <= '0;
      wdat_q    <= '0;
      pkt_q     <= '0;
      err_q     <= '0;
    end else begin
      en_q <= '0;
      if (w_accept) begin
        unique case (state_q)
          HDR_PANEL: begin
            panel_q <= in_data;
            bad_q   <= (in_data == 8'd0) || (in_data > c_MAX_PANEL);
            if (in_last) begin
              err_q   <= err_q + 16'd1;
              state_q <= HDR_PANEL;
            end else begin
              state_q <= HDR_ADDR_HI;
            end
          end
          HDR_ADDR_HI: begin
            addr_hi_q <= in_data;
            if (in_last) begin
              err_q   <= err_q + 16'd1;
              state_q <= HDR_PANEL;
            end else begin
              state_q <= HDR_ADDR_LO;
            end
          end
          HDR_ADDR_LO: begin
            ptr_q <= w_addr;
            if (in_last) begin
              if (!bad_q && w_addr_ok) pkt_q <= pkt_q + 16'd1;
              else                     err_q <= err_q + 16'd1;
              state_q <= HDR_PANEL;
            end else if (bad_q || !w_addr_ok) begin
              state_q <= DROP;
            end else begin
              state_q <= PIX_R;
            end
          end
          PIX_R: begin
            r_q <= in_data;
            if (in_last) begin
              err_q   <= err_q + 16'd1;
              state_q <= HDR_PANEL;
            end else begin
              state_q <= PIX_G;
            end
          end
          PIX_G: begin
            g_q <= in_data;
            if (in_last) begin
              err_q   <= err_q + 16'd1;
              state_q <= HDR_PANEL;
            end else begin
              state_q <= PIX_B;
            end
          end
          PIX_B: begin
            en_q   <= panel_q;
            addr_q <= ptr_q;
            wdat_q <= {in_data, g_q, r_q};
            ptr_q  <= ptr_q + 16'd1;
            // Ending exactly on the last address is clean; any byte after it drops.
            if (in_last) begin
              pkt_q   <= pkt_q + 16'd1;
              state_q <= HDR_PANEL;
            end else if (w_ptr_end) begin
              state_q <= DROP;
            end else begin
              state_q <= PIX_R;
            end
          end
          DROP: begin
            if (in_last) begin
              err_q   <= err_q + 16'd1;
              state_q <= HDR_PANEL;
            end
          end
          default: state_q <= HDR_PANEL;
        endcase
      end
    end
  end

  assign ctrl_en   = en_q;
  assign ctrl_addr = addr_q;
  assign ctrl_wdat = wdat_q;
  assign pkt_count = pkt_q;
  assign err_count = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_stream_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pixel_stream_writer
//  Purpose  : Packet-level reference model with per-cycle output comparison.
//  Revision : 1.0
// ============================================================================
module tb_pixel_stream_writer;

  localparam int NP      = 6;
  localparam int PPP     = 4096;
  localparam int OUT_PKT = 1;
  localparam int OUT_ERR = 2;

  typedef struct packed {
    logic [7:0]  en;
    logic [15:0] addr;
    logic [23:0] wdat;
  } wr_t;

  logic        clk;
  logic        ctrl_reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic [7:0]  ctrl_en;
  logic [15:0] ctrl_addr;
  logic [23:0] ctrl_wdat;
  logic [15:0] pkt_count;
  logic [15:0] err_count;

  pixel_stream_writer #(
    .NUM_PANELS      (NP),
    .PIXELS_PER_PANEL(PPP)
  ) dut (
    .ctrl_clock(clk),
    .ctrl_reset(ctrl_reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .ctrl_en   (ctrl_en),
    .ctrl_addr (ctrl_addr),
    .ctrl_wdat (ctrl_wdat),
    .pkt_count (pkt_count),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  bit          chk_on = 1'b0;
  logic [15:0] exp_pkt = '0;
  logic [15:0] exp_err = '0;
  logic [7:0]  prev_en = '0;
  wr_t         exp_q[$];
  wr_t         m_w[$];
  logic [7:0]  pkt_b[$];

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  // Whole-packet model: which pixels land, and how the packet is accounted.
  function automatic int model_pkt();
    int n, addr, npix, rem;
    logic [7:0] panel;
    bit badhdr;
    m_w.delete();
    n = pkt_b.size();
    if (n < 3) return OUT_ERR;
    panel  = pkt_b[0];
    addr   = int'(pkt_b[1]) * 256 + int'(pkt_b[2]);
    badhdr = (panel == 8'd0) || (int'(panel) > NP) || (addr >= PPP);
    if (badhdr) return OUT_ERR;
    npix = (n - 3) / 3;
    rem  = (n - 3) % 3;
    for (int i = 0; i < npix && addr + i < PPP; i++)
      m_w.push_back({panel, 16'(addr + i), pkt_b[3+3*i+2], pkt_b[3+3*i+1], pkt_b[3+3*i]});
    return (rem == 0 && addr + npix <= PPP) ? OUT_PKT : OUT_ERR;
  endfunction

  task automatic send_pkt(input bit rnd);
    int oc;
    int idle;
    bit v;
    oc = model_pkt();
    foreach (m_w[k]) exp_q.push_back(m_w[k]);
    for (int i = 0; i < pkt_b.size(); i++) begin
      idle = 0;
      do begin
        v = !rnd || (idle >= 6) || ($urandom % 2 == 1);
        in_valid = v;
        in_data  = v ? pkt_b[i] : 8'($urandom);
        in_last  = v ? (i == pkt_b.size() - 1) : 1'($urandom);
        @(posedge clk); #1;
        idle++;
      end while (!v);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (oc == OUT_PKT) exp_pkt = exp_pkt + 16'd1;
    else               exp_err = exp_err + 16'd1;
  endtask

  task automatic drive_byte(input logic [7:0] d, input logic rst);
    in_valid   = 1'b1;
    in_data    = d;
    in_last    = 1'b0;
    ctrl_reset = rst;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      wr_t w, got;
      check("in_ready", 64'(in_ready), 64'(!ctrl_reset));
      check("pkt_count", 64'(pkt_count), 64'(exp_pkt));
      check("err_count", 64'(err_count), 64'(exp_err));
      if (ctrl_en != 8'd0) begin
        check("en_pulse_width", 64'(prev_en), 64'd0);
        got = {ctrl_en, ctrl_addr, ctrl_wdat};
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'(got), 64'd0);
        end else begin
          w = exp_q.pop_front();
          check("write", 64'(got), 64'(w));
        end
      end
      prev_en = ctrl_en;
    end
  end

  initial begin
    int oc, panel, addr, npix, rem, hdrlen, r, kind;
    ctrl_reset = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    in_last    = 1'b0;
    @(posedge clk); #1;
    chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_en", 64'(ctrl_en), 64'd0);
    check("rst_addr", 64'(ctrl_addr), 64'd0);
    check("rst_wdat", 64'(ctrl_wdat), 64'd0);
    check("rst_pkt", 64'(pkt_count), 64'd0);
    check("rst_err", 64'(err_count), 64'd0);
    ctrl_reset = 1'b0;

    // Two clean pixels.
    pkt_b = '{8'h02, 8'h00, 8'h10, 8'hFF, 8'h00, 8'h80, 8'h11, 8'h22, 8'h33};
    oc = model_pkt();
    check("m1_outcome", 64'(oc), 64'(OUT_PKT));
    check("m1_nwr", 64'(m_w.size()), 64'd2);
    check("m1_w0", 64'(m_w[0]), 64'h02_0010_8000FF);
    check("m1_w1", 64'(m_w[1]), 64'h02_0011_332211);
    send_pkt(1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("t1_pkt", 64'(pkt_count), 64'd1);
    check("t1_err", 64'(err_count), 64'd0);

    // Invalid panel indices 0 and 7.
    pkt_b = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    oc = model_pkt();
    check("m2_outcome", 64'(oc), 64'(OUT_ERR));
    check("m2_nwr", 64'(m_w.size()), 64'd0);
    send_pkt(1'b0);
    pkt_b = '{8'h07, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_pkt(1'b0);
    @(posedge clk); #1;
    check("t2_err", 64'(err_count), 64'd2);

    // Overrun past the last address, then a clean end exactly on it.
    pkt_b = '{8'h01, 8'h0F, 8'hFF, 8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hB2, 8'hB3};
    oc = model_pkt();
    check("m3_outcome", 64'(oc), 64'(OUT_ERR));
    check("m3_nwr", 64'(m_w.size()), 64'd1);
    check("m3_addr", 64'(m_w[0].addr), 64'h0FFF);
    send_pkt(1'b0);
    pkt_b = '{8'h01, 8'h0F, 8'hFF, 8'hA1, 8'hA2, 8'hA3};
    send_pkt(1'b0);
    @(posedge clk); #1;
    check("t3_err", 64'(err_count), 64'd3);
    check("t3_pkt", 64'(pkt_count), 64'd2);

    // Truncated on the second pixel's G byte, then a normal packet.
    pkt_b = '{8'h01, 8'h00, 8'h20, 8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hB2};
    oc = model_pkt();
    check("m4_outcome", 64'(oc), 64'(OUT_ERR));
    check("m4_nwr", 64'(m_w.size()), 64'd1);
    send_pkt(1'b0);
    pkt_b = '{8'h03, 8'h01, 8'h00, 8'hC1, 8'hC2, 8'hC3};
    send_pkt(1'b0);
    @(posedge clk); #1;
    check("t4_err", 64'(err_count), 64'd4);
    check("t4_pkt", 64'(pkt_count), 64'd3);

    // Reset coinciding with an accepted B byte.
    drive_byte(8'h03, 1'b0);
    drive_byte(8'h00, 1'b0);
    drive_byte(8'h05, 1'b0);
    drive_byte(8'h11, 1'b0);
    drive_byte(8'h22, 1'b0);
    drive_byte(8'h33, 1'b1);
    exp_pkt = '0;
    exp_err = '0;
    check("rb_in_ready", 64'(in_ready), 64'd0);
    check("rb_en", 64'(ctrl_en), 64'd0);
    check("rb_addr", 64'(ctrl_addr), 64'd0);
    check("rb_wdat", 64'(ctrl_wdat), 64'd0);
    check("rb_pkt", 64'(pkt_count), 64'd0);
    check("rb_err", 64'(err_count), 64'd0);
    ctrl_reset = 1'b0;
    pkt_b = '{8'h04, 8'h00, 8'h07, 8'h44, 8'h55, 8'h66};
    send_pkt(1'b0);

    // Randomized packets with random in_valid gaps.
    for (int p = 0; p < 250; p++) begin
      pkt_b.delete();
      r = $urandom % 16;
      panel = (r == 0) ? 0 : (r == 1) ? 7 : (r == 2) ? int'($urandom % 256) : int'($urandom_range(1, NP));
      kind = $urandom % 8;
      if (kind == 0)     addr = $urandom_range(PPP, 65535);
      else if (kind < 3) addr = PPP - int'($urandom_range(1, 4));
      else               addr = $urandom_range(0, PPP - 1);
      npix   = ($urandom % 10 == 0) ? 64 : int'($urandom_range(0, 6));
      rem    = ($urandom % 4 == 0) ? int'($urandom_range(1, 2)) : 0;
      hdrlen = ($urandom % 20 == 0) ? int'($urandom_range(1, 2)) : 3;
      pkt_b.push_back(8'(panel));
      if (hdrlen >= 2) pkt_b.push_back(8'(addr >> 8));
      if (hdrlen == 3) begin
        pkt_b.push_back(8'(addr));
        for (int b = 0; b < npix * 3 + rem; b++) pkt_b.push_back(8'($urandom));
      end
      send_pkt(1'b1);
    end

    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pixel_stream_writer.md
# pixel_stream_writer

Converts a framed byte stream (one frame per packet, fed by the network receive path) into single-cycle pixel writes on the shared panel control bus (`ctrl_en`/`ctrl_addr`/`ctrl_wdat`). That bus is consumed by every HUB75 panel driver instance in the cube. Each packet carries a target panel index, a start pixel address and a run of RGB888 triplets. The block also does header validation, address-overrun protection and packet/error accounting.

## Interface

Parameters:
- `NUM_PANELS`, 6: highest valid panel index; valid indices are 1..`NUM_PANELS`.
- `PIXELS_PER_PANEL`, 4096: pixel addresses per panel; valid addresses are 0..`PIXELS_PER_PANEL`-1.

Ports:
- `ctrl_clock` in 1: the single clock; all logic on rising edge.
- `ctrl_reset` in 1: synchronous, active-high reset.
- `in_valid` in 1: input byte valid.
- `in_ready` out 1: input accept. Equals 0 while `ctrl_reset`=1, otherwise 1. Never backpressures.
- `in_data` in 8: input byte.
- `in_last` in 1: qualifies the final byte of a packet.
- `ctrl_en` out 8: target panel index during a write cycle; 0 = no write.
- `ctrl_addr` out 16: pixel address, {row, col}.
- `ctrl_wdat` out 24: {B, G, R}; R is in [7:0], G in [15:8], B in [23:16].
- `pkt_count` out 16: packets completed without error; wraps mod 2^16.
- `err_count` out 16: packets terminated by an error; wraps mod 2^16.

## Operation

- Byte accepted = `in_valid` && `in_ready`. Nothing advances on cycles without an accepted byte.
- Packet format:
  - byte 0: panel index.
  - bytes 1-2: start address, big-endian.
  - then R, G, B per pixel, repeated.
- FSM states: `HDR_PANEL` (reset state), `HDR_ADDR_HI`, `HDR_ADDR_LO`, `PIX_R`, `PIX_G`, `PIX_B`, `DROP`.
- `HDR_PANEL`:
  - Latch the index.
  - If the index is 0 or >`NUM_PANELS`, mark the packet bad but still parse the header.
  - Go to `HDR_ADDR_HI`.
- `HDR_ADDR_HI`: latch the high byte, go to `HDR_ADDR_LO`.
- `HDR_ADDR_LO`:
  - Latch the low byte into the address pointer.
  - If the packet is bad, or the address is ≥`PIXELS_PER_PANEL`, go to `DROP`; otherwise go to `PIX_R`.
- `PIX_R` / `PIX_G`: capture the component and advance.
- `PIX_B`:
  - Issue a write: `ctrl_en` = index, `ctrl_addr` = pointer, `ctrl_wdat` = {B,G,R}.
  - Increment the pointer.
  - If the incremented pointer = `PIXELS_PER_PANEL`, go to `DROP` and mark overrun; else go to `PIX_R`.
- `DROP`: consume bytes, no writes, until `in_last`.
- `in_last` handling (always returns to `HDR_PANEL`):
  - `in_last` in `PIX_R`/`PIX_G`: partial pixel discarded, `err_count`+1.
  - `in_last` in `HDR_PANEL`/`HDR_ADDR_HI`: truncated header, `err_count`+1.
  - `in_last` in `HDR_ADDR_LO`:
    - Good header with a valid address: empty packet, `pkt_count`+1.
    - Otherwise: `err_count`+1.
  - `in_last` in `PIX_B`:
    - The write still issues.
    - `pkt_count`+1 on a clean end, including when this write is at the last address.
  - `in_last` in `DROP`: `err_count`+1.
- Overrun:
  - A packet whose last pixel lands exactly on `PIXELS_PER_PANEL`-1 with `in_last` is clean.
  - If any further byte follows, the packet counts as an error (`err_count`+1 once, at `in_last`).
- At most one counter increments per packet.

## Timing

- Reset values: `ctrl_en`=0, `ctrl_addr`=0, `ctrl_wdat`=0, `pkt_count`=0, `err_count`=0, `in_ready`=0, FSM=`HDR_PANEL`, pointer=0.
- Write latency: `ctrl_en`/`ctrl_addr`/`ctrl_wdat` are registered and valid in the cycle after the B byte is accepted.
- `ctrl_en` is nonzero for exactly one cycle per write, then returns to 0.
- `ctrl_addr`/`ctrl_wdat` hold their last value while `ctrl_en`=0.
- Minimum spacing between writes is 3 cycles, since each pixel takes 3 bytes and one byte is accepted per cycle.
- Counters update in the cycle after the `in_last` byte is accepted.
- Back-to-back packets: a header byte may be accepted in the cycle immediately following the `in_last` byte.
- Reset mid-packet:
  - Returns to `HDR_PANEL` with no write and no count.
  - A write registered in the reset cycle is cancelled (`ctrl_en`=0 next cycle).
  - Remaining bytes are parsed as a new header; this is required behaviour.

## Test plan

- Packet 02 00 10 FF 00 80 11 22 33 (last on 33) -> writes (en=2, addr=0x0010, wdat=0x8000FF), then (en=2, addr=0x0011, wdat=0x332211); `pkt_count`=1, `err_count`=0.
- Panel index 00, then index 07 with `NUM_PANELS`=6, each followed by 6 pixel bytes -> no writes; `err_count`=2.
- Header 01 0F FF, then two pixels -> one write at addr 0x0FFF; overrun; `err_count`=1, `pkt_count`=0. Same case with `in_last` on the first pixel's B -> `pkt_count`=1.
- `in_last` on the G byte of the second pixel -> only the first write issued; `err_count`+1; the next packet parses correctly from its header.
- `in_valid` toggled randomly every cycle across 64-pixel packets -> writes equal a golden model with identical addresses and data; `ctrl_en` pulses never exceed 1 cycle.
- `ctrl_reset` asserted on the cycle a B byte is accepted -> no write; all outputs zero the next cycle; `in_ready`=0 during reset.
